// File: rtl/iterative_multiplier_pkg.sv
// Shared opcode and FSM state encodings for the iterative shift-add multiplier.
package iterative_multiplier_pkg;

  localparam logic [1:0] OP_MUL   = 2'b00;
  localparam logic [1:0] OP_UMULH = 2'b01;
  localparam logic [1:0] OP_SMULH = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_WB   = 2'b11
  } state_t;

endpackage

// File: rtl/iterative_multiplier_if.sv
// Issue-side request bus and register-file write-back bus of the multiply unit.
interface iterative_multiplier_if #(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
);
  logic             Start;
  logic             Flush;
  logic [1:0]       Op;
  logic [WIDTH-1:0] OpA;
  logic [WIDTH-1:0] OpB;
  logic [RA_W-1:0]  Dst;
  logic             Ready;
  logic             Busy;
  logic [WIDTH-1:0] BusW;
  logic [RA_W-1:0]  RW;
  logic             RegWr;

  modport master (
    output Start, Flush, Op, OpA, OpB, Dst,
    input  Ready, Busy, BusW, RW, RegWr
  );

  modport slave (
    input  Start, Flush, Op, OpA, OpB, Dst,
    output Ready, Busy, BusW, RW, RegWr
  );
endinterface

// File: rtl/iterative_multiplier_mul_step.sv
// One shift-add iteration: conditionally add the multiplicand into the upper half, then shift right.
module mul_step #(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH:0]  p,
  input  logic [WIDTH-1:0]  mcand,
  output logic [2*WIDTH:0]  pNext
);
  logic [WIDTH:0]   sum_s;
  logic [2*WIDTH:0] added_s;

  // Add (with carry into bit 2W) when the current multiplier bit is set, then shift.
  always_comb begin
    sum_s = {1'b0, p[2*WIDTH-1:WIDTH]} + {1'b0, mcand};
    if (p[0]) begin
      added_s = {sum_s, p[WIDTH-1:0]};
    end else begin
      added_s = p;
    end
    pNext = added_s >> 1;
  end
endmodule

// File: rtl/iterative_multiplier.sv
// Multi-cycle MUL/UMULH/SMULH unit: WIDTH shift-add steps, sign fixup, one-cycle register-file write.
module iterative_multiplier
  import iterative_multiplier_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RA_W  = 5
) (
  input logic                  Clk,
  input logic                  Reset,
  iterative_multiplier_if.slave bus
);
  localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  state_t           state_r;
  state_t           stateNext_s;
  logic [2*WIDTH:0] p_r;
  logic [2*WIDTH:0] pStep_s;
  logic [WIDTH-1:0] mcand_r;
  logic [CW-1:0]    count_r;
  logic [1:0]       op_r;
  logic [RA_W-1:0]  dst_r;
  logic             neg_r;
  logic             ready_r;
  logic             regWr_r;
  logic [WIDTH-1:0] busW_r;
  logic [RA_W-1:0]  rw_r;

  logic             isSigned_s;
  logic [WIDTH-1:0] absA_s;
  logic [WIDTH-1:0] absB_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] result_s;

  // Magnitude as unsigned: the most negative value maps onto itself without overflow.
  function automatic logic [WIDTH-1:0] absVal(input logic [WIDTH-1:0] v);
    absVal = v[WIDTH-1] ? (~v + WIDTH'(1)) : v;
  endfunction

  mul_step #(.WIDTH(WIDTH)) uStep (
    .p     (p_r),
    .mcand (mcand_r),
    .pNext (pStep_s)
  );

  assign bus.Ready = ready_r;
  assign bus.Busy  = ~ready_r;
  assign bus.RegWr = regWr_r;
  assign bus.BusW  = busW_r;
  assign bus.RW    = rw_r;

  // Next-state logic; Flush returns to IDLE from any state and beats Start.
  always_comb begin
    stateNext_s = state_r;
    if (bus.Flush) begin
      stateNext_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: stateNext_s = bus.Start ? ST_CALC : ST_IDLE;
        ST_CALC: stateNext_s = (count_r == LAST) ? ST_FIX : ST_CALC;
        ST_FIX:  stateNext_s = ST_WB;
        ST_WB:   stateNext_s = ST_IDLE;
        default: stateNext_s = ST_IDLE;
      endcase
    end
  end

  // Operand conditioning at issue and sign fixup / half select at FIX.
  always_comb begin
    isSigned_s = (bus.Op == OP_SMULH);
    absA_s     = absVal(bus.OpA);
    absB_s     = absVal(bus.OpB);
    prod_s     = neg_r ? (~p_r[2*WIDTH-1:0] + (2*WIDTH)'(1)) : p_r[2*WIDTH-1:0];
    case (op_r)
      OP_MUL:   result_s = prod_s[WIDTH-1:0];
      OP_UMULH: result_s = prod_s[2*WIDTH-1:WIDTH];
      OP_SMULH: result_s = prod_s[2*WIDTH-1:WIDTH];
      default:  result_s = prod_s[WIDTH-1:0];
    endcase
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_r <= ST_IDLE;
      p_r     <= '0;
      mcand_r <= '0;
      count_r <= '0;
      op_r    <= 2'b00;
      dst_r   <= '0;
      neg_r   <= 1'b0;
      ready_r <= 1'b1;
      regWr_r <= 1'b0;
      busW_r  <= '0;
      rw_r    <= '0;
    end else begin
      state_r <= stateNext_s;
      ready_r <= (stateNext_s == ST_IDLE);
      regWr_r <= (stateNext_s == ST_WB) && (dst_r != '0);
      case (state_r)
        ST_IDLE: begin
          if (bus.Start && !bus.Flush) begin
            op_r    <= bus.Op;
            dst_r   <= bus.Dst;
            mcand_r <= isSigned_s ? absA_s : bus.OpA;
            p_r     <= {{(WIDTH+1){1'b0}}, (isSigned_s ? absB_s : bus.OpB)};
            neg_r   <= isSigned_s & (bus.OpA[WIDTH-1] ^ bus.OpB[WIDTH-1]);
            count_r <= '0;
          end else begin
            count_r <= '0;
          end
        end
        ST_CALC: begin
          p_r     <= pStep_s;
          count_r <= (stateNext_s == ST_CALC) ? (count_r + CW'(1)) : '0;
        end
        ST_FIX: begin
          if (!bus.Flush) begin
            busW_r <= result_s;
            rw_r   <= dst_r;
          end else begin
            rw_r   <= rw_r;
          end
        end
        default: begin
          count_r <= '0;
        end
      endcase
    end
  end
endmodule
